// File: rtl/pos_screen_ctrl.sv
// pos_screen_ctrl: POS sale sequencer with switch debouncing and frame-latched display outputs
module pos_screen_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PRICE_STEP = 125,
  parameter int MAX_ITEMS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic        vsync,
  output logic [2:0]  screen_sel,
  output logic [3:0]  disp_item,
  output logic [3:0]  disp_count,
  output logic [15:0] disp_total,
  output logic        busy
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, PAY = 3'd2, RECEIPT = 3'd3, ERR = 3'd4} state_t;
  state_t state, state_n;
  logic [7:0] sw_m, sw_s, db;
  logic [1:0] db_q;
  logic [CW-1:0] cnt [8];
  logic [3:0] count, item, code;
  logic [15:0] total;
  logic [31:0] sum;
  logic vs_q, vs_qq, confirm_p, cancel_p, conf, add, clear, unused_sw;
  assign unused_sw = ^db[5:4];
  assign confirm_p = db[7] & ~db_q[1];
  assign cancel_p = db[6] & ~db_q[0];
  assign conf = confirm_p & ~cancel_p;
  assign code = (state == IDLE && db[3:0] == 4'hF) ? 4'hE : db[3:0];
  assign sum = 32'(total) + (32'(code) + 32'd1) * 32'(PRICE_STEP);
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else
      for (int i = 0; i < 8; i++)
        if (sw_s[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[i] <= sw_s[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
  always_comb begin
    state_n = state;
    add = 1'b0;
    clear = 1'b0;
    case (state)
      IDLE: if (conf) begin
        state_n = ENTRY;
        add = 1'b1;
      end
      ENTRY: if (cancel_p) begin
        state_n = IDLE;
        clear = 1'b1;
      end else if (conf) begin
        if (db[3:0] == 4'hF) state_n = PAY;
        else if (32'(count) == 32'(MAX_ITEMS)) state_n = ERR;
        else add = 1'b1;
      end
      PAY: state_n = cancel_p ? ENTRY : conf ? RECEIPT : PAY;
      RECEIPT: if (cancel_p | confirm_p) begin
        state_n = IDLE;
        clear = 1'b1;
      end
      ERR: state_n = (cancel_p | confirm_p) ? ENTRY : ERR;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      sw_m <= '0;
      sw_s <= '0;
      db_q <= '0;
      vs_q <= 1'b0;
      vs_qq <= 1'b0;
      state <= IDLE;
      count <= '0;
      item <= '0;
      total <= '0;
      screen_sel <= '0;
      disp_item <= '0;
      disp_count <= '0;
      disp_total <= '0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
      db_q <= db[7:6];
      vs_q <= vsync;
      vs_qq <= vs_q;
      state <= state_n;
      count <= clear ? '0 : add ? count + 1'b1 : count;
      item <= add ? code : item;
      total <= clear ? '0 : add ? (sum > 32'hFFFF ? 16'hFFFF : sum[15:0]) : total;
      if (vs_qq & ~vs_q) begin
        screen_sel <= state;
        disp_item <= item;
        disp_count <= count;
        disp_total <= total;
      end
    end
endmodule

// File: tb/tb_pos_screen_ctrl.sv
// tb_pos_screen_ctrl: table, directed and random checks of pos_screen_ctrl against a sale-level model
module tb_pos_screen_ctrl;
  localparam int DEB = 8;
  localparam int SETTLE = DEB + 6;
  logic clk = 1'b0, rst = 1'b1, vsync = 1'b1;
  logic [7:0] sw = '0;
  logic [2:0] a_scr, b_scr;
  logic [3:0] a_item, b_item, a_cnt, b_cnt;
  logic [15:0] a_tot, b_tot;
  logic a_busy, b_busy;
  int checks = 0, failures = 0;
  int m_state, m_count, m_item;
  int m_total [2];
  int step [2] = '{125, 8000};
  typedef struct { bit conf; bit canc; logic [3:0] code; int scr; int cnt; int tot; int item; } vec_t;
  vec_t tbl [5];
  always #5 clk = ~clk;
  pos_screen_ctrl #(.DEBOUNCE_CYCLES(DEB), .PRICE_STEP(125), .MAX_ITEMS(15)) dut_a (
    .clk(clk), .rst(rst), .sw(sw), .vsync(vsync), .screen_sel(a_scr),
    .disp_item(a_item), .disp_count(a_cnt), .disp_total(a_tot), .busy(a_busy));
  pos_screen_ctrl #(.DEBOUNCE_CYCLES(DEB), .PRICE_STEP(8000), .MAX_ITEMS(15)) dut_b (
    .clk(clk), .rst(rst), .sw(sw), .vsync(vsync), .screen_sel(b_scr),
    .disp_item(b_item), .disp_count(b_cnt), .disp_total(b_tot), .busy(b_busy));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0;
    m_count = 0;
    m_item = 0;
    m_total = '{0, 0};
  endtask
  task automatic model_add(input int c);
    m_count++;
    m_item = c;
    for (int k = 0; k < 2; k++) m_total[k] = (m_total[k] + (c + 1) * step[k] > 65535) ? 65535 : m_total[k] + (c + 1) * step[k];
  endtask
  task automatic model_op(input bit c, input bit x, input int code);
    if (x) begin
      if (m_state == 1 || m_state == 3) begin
        m_state = 0;
        m_count = 0;
        m_total = '{0, 0};
      end else if (m_state == 2 || m_state == 4) m_state = 1;
    end else if (c) begin
      if (m_state == 0) begin
        model_add(code == 15 ? 14 : code);
        m_state = 1;
      end else if (m_state == 1) begin
        if (code == 15) m_state = 2;
        else if (m_count == 15) m_state = 4;
        else model_add(code);
      end else if (m_state == 2) m_state = 3;
      else if (m_state == 3) begin
        m_state = 0;
        m_count = 0;
        m_total = '{0, 0};
      end else m_state = 1;
    end
  endtask
  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask
  task automatic do_op(input bit c, input bit x, input logic [3:0] code);
    sw[3:0] = code;
    settle();
    sw[7] = c;
    sw[6] = x;
    settle();
    model_op(c, x, int'(code));
    sw[7:6] = 2'b00;
    settle();
  endtask
  task automatic frame();
    @(negedge clk) vsync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) vsync = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic check_model(input string tag);
    chk({tag, " a_screen"}, int'(a_scr), m_state);
    chk({tag, " a_count"}, int'(a_cnt), m_count);
    chk({tag, " a_item"}, int'(a_item), m_item);
    chk({tag, " a_total"}, int'(a_tot), m_total[0]);
    chk({tag, " a_busy"}, int'(a_busy), int'(m_state != 0));
    chk({tag, " b_screen"}, int'(b_scr), m_state);
    chk({tag, " b_count"}, int'(b_cnt), m_count);
    chk({tag, " b_total"}, int'(b_tot), m_total[1]);
    chk({tag, " b_busy"}, int'(b_busy), int'(m_state != 0));
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'd2, 1, 1, 375, 2};
    tbl[1] = '{1'b1, 1'b0, 4'd5, 1, 2, 1125, 5};
    tbl[2] = '{1'b1, 1'b0, 4'hF, 2, 2, 1125, 5};
    tbl[3] = '{1'b1, 1'b0, 4'd0, 3, 2, 1125, 5};
    tbl[4] = '{1'b0, 1'b1, 4'd0, 0, 0, 0, 5};
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    frame();
    check_model("reset");
    for (int i = 0; i < 5; i++) begin
      do_op(tbl[i].conf, tbl[i].canc, tbl[i].code);
      frame();
      chk($sformatf("sale%0d screen", i), int'(a_scr), tbl[i].scr);
      chk($sformatf("sale%0d count", i), int'(a_cnt), tbl[i].cnt);
      chk($sformatf("sale%0d total", i), int'(a_tot), tbl[i].tot);
      chk($sformatf("sale%0d item", i), int'(a_item), tbl[i].item);
      check_model($sformatf("sale%0d", i));
    end
    sw[3:0] = 4'd3;
    settle();
    sw[7] = 1'b1;
    repeat (5) @(negedge clk);
    sw[7] = 1'b0;
    settle();
    frame();
    chk("glitch screen", int'(a_scr), 0);
    chk("glitch count", int'(a_cnt), 0);
    check_model("glitch");
    sw[7] = 1'b1;
    repeat (20) @(negedge clk);
    model_op(1'b1, 1'b0, 3);
    sw[7] = 1'b0;
    settle();
    frame();
    chk("hold count", int'(a_cnt), 1);
    chk("hold total", int'(a_tot), 500);
    check_model("hold");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 16; k++) begin
      do_op(1'b1, 1'b0, 4'd0);
      if (k == 8 || k == 9 || k == 15 || k == 16) begin
        frame();
        check_model($sformatf("limit%0d", k));
      end
      if (k == 8) chk("b total before sat", int'(b_tot), 64000);
      if (k == 9) chk("b total saturated", int'(b_tot), 65535);
    end
    chk("overflow screen", int'(a_scr), 4);
    chk("overflow count", int'(a_cnt), 15);
    do_op(1'b1, 1'b0, 4'd0);
    frame();
    chk("err exit screen", int'(a_scr), 1);
    chk("err exit count", int'(a_cnt), 15);
    do_op(1'b0, 1'b1, 4'd0);
    frame();
    check_model("cancel");
    do_op(1'b1, 1'b0, 4'd4);
    chk("hold screen", int'(a_scr), 0);
    chk("hold item", int'(a_item), 0);
    chk("hold disp count", int'(a_cnt), 0);
    chk("live busy", int'(a_busy), 1);
    @(negedge clk) vsync = 1'b0;
    @(posedge clk) #1;
    chk("latch early screen", int'(a_scr), 0);
    @(posedge clk) #1;
    chk("latch screen", int'(a_scr), 1);
    chk("latch item", int'(a_item), 4);
    chk("latch count", int'(a_cnt), 1);
    chk("latch total", int'(a_tot), 625);
    @(negedge clk) vsync = 1'b1;
    do_op(1'b1, 1'b1, 4'd4);
    frame();
    chk("both screen", int'(a_scr), 0);
    chk("both total", int'(a_tot), 0);
    check_model("both");
    do_op(1'b1, 1'b0, 4'd1);
    do_op(1'b1, 1'b0, 4'hF);
    frame();
    chk("pay screen", int'(a_scr), 2);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    chk("rst screen", int'(a_scr), 0);
    chk("rst count", int'(a_cnt), 0);
    chk("rst total", int'(a_tot), 0);
    chk("rst item", int'(a_item), 0);
    chk("rst busy", int'(a_busy), 0);
    chk("rst b total", int'(b_tot), 0);
    @(negedge clk) rst = 1'b0;
    model_reset();
    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7) do_op(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      else if (r < 9) do_op(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      else do_op(1'b1, 1'b1, 4'($urandom_range(0, 15)));
      frame();
      check_model($sformatf("rand%0d", n));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
